// File: rtl/z_core_pkg.sv
// Shared Z-Core decode definitions: opcode values, funct7 constants and the
// immediate-format encoding used by the decode stage and immediate generator.
package z_core_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

endpackage

// File: rtl/z_core_imm_gen.sv
// Combinational immediate generator.
// Ports:
//   inst     in  32    raw instruction word
//   imm_fmt  out 3     immediate format selected by opcode
//   imm      out XLEN  assembled immediate, sign-extended from inst[31]
module z_core_imm_gen
  import z_core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     inst,
  output imm_fmt_e        imm_fmt,
  output logic [XLEN-1:0] imm
);

  logic w_sign;
  assign w_sign = inst[31];

  always_comb begin
    imm_fmt = IMM_NONE;
    imm     = '0;
    case (inst[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        imm_fmt = IMM_I;
        imm     = {{(XLEN-11){w_sign}}, inst[30:20]};
      end
      OP_STORE: begin
        imm_fmt = IMM_S;
        imm     = {{(XLEN-11){w_sign}}, inst[30:25], inst[11:7]};
      end
      OP_BRANCH: begin
        imm_fmt = IMM_B;
        imm     = {{(XLEN-12){w_sign}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        imm_fmt = IMM_U;
        imm     = {{(XLEN-31){w_sign}}, inst[30:12], 12'b0};
      end
      OP_JAL: begin
        imm_fmt = IMM_J;
        imm     = {{(XLEN-20){w_sign}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      default: begin
        imm_fmt = IMM_NONE;
        imm     = '0;
      end
    endcase
  end

endmodule

// File: rtl/z_core_decode_stage.sv
// Z-Core instruction decode stage: decodes fetched instructions on the push
// path and buffers decoded bundles in a DEPTH-entry FIFO with valid/ready
// handshakes on both sides. Flush and reset empty the FIFO.
// Optional feature macro: Z_CORE_M_EXT_EN (OP with funct7=0000001 is legal).
// Ports:
//   clk, rst (sync, active-high), flush
//   in_valid/in_ready/in_inst/in_pc        fetch side
//   out_valid/out_ready + decoded fields   consumer side
//   out_count                              occupied entries
module z_core_decode_stage
  import z_core_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [6:0]               out_op,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [2:0]               out_funct3,
  output logic [6:0]               out_funct7,
  output logic [XLEN-1:0]          out_imm,
  output logic [2:0]               out_imm_fmt,
  output logic                     out_illegal,
  output logic [XLEN-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]   out_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [6:0]      op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_fmt;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } bundle_t;

  bundle_t         r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  imm_fmt_e        w_imm_fmt;
  logic [XLEN-1:0] w_imm;
  logic            w_illegal;
  bundle_t         w_dec;
  bundle_t         w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;

  z_core_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst    (in_inst),
    .imm_fmt (w_imm_fmt),
    .imm     (w_imm)
  );

  always_comb begin
    w_illegal = 1'b0;
    case (in_inst[6:0])
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_STORE,
      OP_IMM, OP_FENCE, OP_SYSTEM: w_illegal = 1'b0;
      OP_BRANCH: w_illegal = (in_inst[14:12] == 3'b010) || (in_inst[14:12] == 3'b011);
      OP_OP: begin
        case (in_inst[31:25])
          F7_BASE:   w_illegal = 1'b0;
          F7_ALT:    w_illegal = !((in_inst[14:12] == 3'b000) || (in_inst[14:12] == 3'b101));
`ifdef Z_CORE_M_EXT_EN
          F7_MULDIV: w_illegal = 1'b0;
`else
          F7_MULDIV: w_illegal = 1'b1;
`endif
          default:   w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_dec         = '0;
    w_dec.op      = in_inst[6:0];
    w_dec.rd      = in_inst[11:7];
    w_dec.rs1     = in_inst[19:15];
    w_dec.rs2     = in_inst[24:20];
    w_dec.funct3  = in_inst[14:12];
    w_dec.funct7  = in_inst[31:25];
    w_dec.imm     = w_imm;
    w_dec.imm_fmt = w_imm_fmt;
    w_dec.illegal = w_illegal;
    w_dec.pc      = in_pc;
  end

  // Handshake flags depend only on the registered count; a pop in the full
  // cycle does not open in_ready.
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign out_count = r_count;
  assign w_push    = in_valid && in_ready && !flush && !rst;
  assign w_pop     = out_valid && out_ready && !flush && !rst;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; zeroing the head while empty gives all-zero
  // outputs after reset or flush.
  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

  assign out_op      = w_head.op;
  assign out_rd      = w_head.rd;
  assign out_rs1     = w_head.rs1;
  assign out_rs2     = w_head.rs2;
  assign out_funct3  = w_head.funct3;
  assign out_funct7  = w_head.funct7;
  assign out_imm     = w_head.imm;
  assign out_imm_fmt = w_head.imm_fmt;
  assign out_illegal = w_head.illegal;
  assign out_pc      = w_head.pc;

endmodule

// File: tb/tb_z_core_decode_stage.sv
module tb_z_core_decode_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;

`ifdef Z_CORE_M_EXT_EN
  localparam logic ILL_M = 1'b0;
`else
  localparam logic ILL_M = 1'b1;
`endif

  typedef struct packed {
    logic [6:0]      op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
    logic [XLEN-1:0] pc;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]            in_inst;
  logic [XLEN-1:0]        in_pc;
  logic [6:0]             out_op, out_funct7;
  logic [4:0]             out_rd, out_rs1, out_rs2;
  logic [2:0]             out_funct3, out_imm_fmt;
  logic [XLEN-1:0]        out_imm, out_pc;
  logic                   out_illegal;
  logic [$clog2(DEPTH):0] out_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  z_core_decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
    .out_imm_fmt(out_imm_fmt), .out_illegal(out_illegal), .out_pc(out_pc),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [XLEN-1:0] imm, input logic [2:0] fmt, input logic ill,
                              input logic [XLEN-1:0] pc);
    exp_t e;
    e = '{op: op, rd: rd, rs1: rs1, rs2: rs2, funct3: f3, funct7: f7,
          imm: imm, fmt: fmt, ill: ill, pc: pc};
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each accepted output bundle is matched against the
  // oldest expected entry.
  always @(negedge clk) begin
    exp_t act, e;
    if (!rst && !flush && out_valid && out_ready) begin
      act = '{op: out_op, rd: out_rd, rs1: out_rs1, rs2: out_rs2, funct3: out_funct3,
              funct7: out_funct7, imm: out_imm, fmt: out_imm_fmt, ill: out_illegal, pc: out_pc};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got %h, expected nothing", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL bundle pc=%0h: got %h, expected %h", e.pc, act, e);
        end
      end
    end
  end

  task automatic push(input logic [31:0] inst, input exp_t e);
    bit ok = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = e.pc;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout pc=%0h: got in_ready=0, expected 1", e.pc);
    end else begin
      @(posedge clk);
      exp_q.push_back(e);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  exp_t v[10];

  initial begin
    v[0] = mk(7'h13,  2,  0,  3, 3'd0, 7'h00, 32'h3,        3'd1, 1'b0,  32'h100);
    v[1] = mk(7'h23, 16,  1,  2, 3'd0, 7'h00, 32'h10,       3'd2, 1'b0,  32'h104);
    v[2] = mk(7'h63, 29,  0,  0, 3'd0, 7'h7F, 32'hFFFFFFFC, 3'd3, 1'b0,  32'h108);
    v[3] = mk(7'h33,  0,  1,  2, 3'd0, 7'h01, 32'h0,        3'd0, ILL_M, 32'h10C);
    v[4] = mk(7'h7F, 31, 31, 31, 3'd7, 7'h7F, 32'h0,        3'd0, 1'b1,  32'h110);
    v[5] = mk(7'h33,  0,  1,  2, 3'd0, 7'h20, 32'h0,        3'd0, 1'b0,  32'h114);
    v[6] = mk(7'h33,  0,  1,  2, 3'd1, 7'h20, 32'h0,        3'd0, 1'b1,  32'h118);
    v[7] = mk(7'h63,  0,  0,  0, 3'd2, 7'h00, 32'h0,        3'd3, 1'b1,  32'h11C);
    v[8] = mk(7'h37,  0,  8,  3, 3'd5, 7'h09, 32'h12345000, 3'd4, 1'b0,  32'h120);
    v[9] = mk(7'h6F,  0,  0,  8, 3'd0, 7'h00, 32'h8,        3'd5, 1'b0,  32'h124);

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_count",     64'(out_count), 64'd0);
    chk("reset_in_ready",  64'(in_ready),  64'd1);
    chk("reset_out_imm",   64'(out_imm),   64'd0);
    rst = 1'b0;

    // Latency from empty, then fill to DEPTH with consumer stalled.
    push(32'h00300113, v[0]);
    chk("latency_out_valid", 64'(out_valid), 64'd1);
    chk("count_one",         64'(out_count), 64'd1);
    push(32'h00208823, v[1]);
    chk("full_count",    64'(out_count), 64'(DEPTH));
    chk("full_in_ready", 64'(in_ready),  64'd0);

    // Push offered in the full cycle while a pop happens: push refused.
    out_ready = 1'b1;
    in_valid  = 1'b1; in_inst = 32'hFE000EE3; in_pc = 32'h108;
    @(negedge clk);
    chk("full_pop_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full_pop_count", 64'(out_count), 64'd1);

    // Streaming with consumer ready: wraps pointers, covers all formats.
    push(32'hFE000EE3, v[2]);
    push(32'h02208033, v[3]);
    push(32'hFFFFFFFF, v[4]);
    push(32'h40208033, v[5]);
    push(32'h40209033, v[6]);
    push(32'h00002063, v[7]);
    push(32'h12345037, v[8]);
    push(32'h0080006F, v[9]);
    drain();
    chk("drained_count", 64'(out_count), 64'd0);

    // Flush with a concurrent push: everything dropped.
    out_ready = 1'b0;
    push(32'h00300113, v[0]);
    push(32'h00208823, v[1]);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h12345037; in_pc = 32'h120;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_count",     64'(out_count), 64'd0);
    chk("flush_in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1;
    push(32'h0080006F, v[9]);
    drain();

    // Reset mid-stream with one buffered entry.
    out_ready = 1'b0;
    push(32'hFE000EE3, v[2]);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    chk("rst_out_valid",  64'(out_valid),   64'd0);
    chk("rst_count",      64'(out_count),   64'd0);
    chk("rst_in_ready",   64'(in_ready),    64'd1);
    chk("rst_out_pc",     64'(out_pc),      64'd0);
    chk("rst_out_imm",    64'(out_imm),     64'd0);
    chk("rst_out_fmt",    64'(out_imm_fmt), 64'd0);
    chk("rst_out_funct7", 64'(out_funct7),  64'd0);
    out_ready = 1'b1;
    push(32'h00208823, v[1]);
    drain();

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/z_core_decode_stage.md
# z_core_decode_stage

Registered, parametrised RISC-V instruction decode stage for Z-Core, sitting between fetch and register-read/execute. It buffers fetched instructions in a small FIFO, decodes each one into register indices, function fields, a format-selected sign-extended immediate and an illegal-instruction flag, and presents the result over a valid/ready handshake. Flush support covers branch redirects.

## Interface
- XLEN, 32: datapath width. Legal values are 32 and 64. Immediates are sign-extended to XLEN; `pc` is XLEN wide.
- DEPTH, 2: number of FIFO entries. Must be a power of two and at least 2.
- clk  in  1  Single clock; all state updates on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- flush  in  1  Discards all buffered entries.
- in_valid  in  1  Fetch presents an instruction.
- in_ready  out  1  Stage can accept an instruction.
- in_inst  in  32  Raw instruction word.
- in_pc  in  XLEN  PC of `in_inst`.
- out_valid  out  1  Decoded bundle is valid.
- out_ready  in  1  Consumer accepts the bundle.
- out_op  out  7  `inst[6:0]`.
- out_rd, out_rs1, out_rs2  out  5 each  `inst[11:7]`, `inst[19:15]` and `inst[24:20]` respectively.
- out_funct3  out  3  `inst[14:12]`.
- out_funct7  out  7  `inst[31:25]`.
- out_imm  out  XLEN  Immediate for the decoded format, sign-extended.
- out_imm_fmt  out  3  Immediate format: I, S, B, U, J or NONE.
- out_illegal  out  1  Opcode or funct combination is not supported.
- out_pc  out  XLEN  PC of the decoded instruction.
- out_count  out  $clog2(DEPTH)+1  Number of occupied entries.

## Operation
- Decoding happens on the push path. The FIFO stores decoded bundles, not raw words.
- Immediate format is selected by opcode:
  - OP-IMM, LOAD, JALR, SYSTEM → I
  - STORE → S
  - BRANCH → B
  - LUI, AUIPC → U
  - JAL → J
  - OP → NONE, with `out_imm` = 0
- Immediate bit assembly follows the RV32I base encodings. Sign bit is `inst[31]`, replicated to XLEN.
- Legal opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM.
  - Any other opcode → `out_illegal` = 1, `out_imm_fmt` = NONE.
  - OP with funct7 other than 0000000, or 0100000 paired with funct3 000/101 → illegal.
  - BRANCH with funct3 010 or 011 → illegal.
- Illegal instructions are still buffered and delivered. Trapping is downstream's responsibility.
- A push occurs when `in_valid && in_ready`. A pop occurs when `out_valid && out_ready`.
- `in_ready` = !full. There is no same-cycle bypass: when full, `in_ready` stays 0 even if a pop happens that cycle.
- Simultaneous push and pop when neither empty nor full → count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. A separate count register distinguishes full from empty.
- Flush: count and both pointers go to 0 at the next edge. A push in the same cycle is dropped (flush wins). `in_ready` is not gated by flush.
- Reset: identical effect to flush. All out_* data fields are 0, `out_valid` = 0, `out_count` = 0, `in_ready` = 1 after the reset edge.

## Timing
- Latency: an instruction pushed at edge N appears with `out_valid` = 1 in the cycle after edge N (1 cycle) when the FIFO was empty.
- Throughput: one instruction per cycle sustained when `out_ready` is held high.
- `out_*` data fields are taken from the head entry. They are stable while `out_valid && !out_ready`.
- `in_ready` and `out_valid` are driven from registered count only, with no combinational path from `in_valid` or `out_ready`.
- Reset asserted mid-stream: contents are lost at that edge. No handshake is honoured in the reset cycle.

## Configuration
- `Z_CORE_M_EXT_EN` defined: OP with funct7 = 0000001 (MUL/DIV, all funct3) is legal with `out_imm_fmt` = NONE.
- `Z_CORE_M_EXT_EN` undefined: that encoding is flagged `out_illegal` = 1.

## Structure
- Shared package `z_core_pkg` holds:
  - opcode localparams: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM
  - the imm_fmt encoding: NONE=0, I=1, S=2, B=3, U=4, J=5
  - the funct7 constants
- One sub-module, `z_core_imm_gen`: combinational, takes `inst` and returns `imm_fmt` and `imm[XLEN-1:0]`. It is instantiated once on the push path.

## Test plan
- Reset, then push 0x00300113 with pc 0x100 → next cycle: `out_valid` = 1, op 0010011, rd 2, rs1 0, funct3 0, imm 3, fmt I, pc 0x100, illegal 0.
- Push 0x00208823 → op 0100011, rs1 1, rs2 2, funct3 0, imm 16, fmt S. Then push 0xFE000EE3 → fmt B, imm −4 (all ones except `[1:0]` = 00).
- Hold `out_ready` low and push DEPTH entries → `in_ready` = 0, `out_count` = DEPTH. Push while pop in the full cycle → push refused. Drain → entries come out in order and pointers wrap correctly.
- Push 0x02208033 (MUL) → `out_illegal` = 1 without the macro and 0 with it. Push 0xFFFFFFFF → illegal in both builds.
- Fill 2 entries, assert flush together with `in_valid` → next cycle `out_valid` = 0, `out_count` = 0, flushed push is not delivered.
- Assert rst while 1 entry is buffered and `out_ready` = 0 → next cycle all outputs are at reset values and `in_ready` = 1.
